// File: rtl/module_bin_bcd_if.sv
// Request/result bundle between the binary source and the BCD converter.
// master drives the request side (bin_input/start); slave is the converter.
interface bcd_if #(
    parameter int WIDTH = 14
) ();
    logic [WIDTH-1:0] bin_input;
    logic             start;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [3:0]       unidades;
    logic [3:0]       decenas;
    logic [3:0]       centenas;
    logic [3:0]       milesimas;

    modport master (
        output bin_input, start,
        input  busy, done, overflow, unidades, decenas, centenas, milesimas
    );

    modport slave (
        input  bin_input, start,
        output busy, done, overflow, unidades, decenas, centenas, milesimas
    );
endinterface

// File: rtl/module_bin_bcd.sv
// Iterative binary-to-BCD converter (shift-and-add-3, one input bit per clk).
// Four digits are produced for the downstream 7-segment decoder and held
// between conversions; inputs above MAX_VALUE saturate and flag overflow.

// Per-digit correction cell: a nibble >= 5 gets 3 added before the shift so
// the shift carries into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module module_bin_bcd #(
    parameter int WIDTH     = 14,
    parameter int MAX_VALUE = 9999
) (
    input  logic clk,
    input  logic rst,
    bcd_if.slave bus
);
    localparam int NUM_DIGITS = 4;
    localparam int SR_W       = WIDTH + 4 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                          state, state_nxt;
    logic [SR_W-1:0]                 sr;
    logic [SR_W-1:0]                 sr_step;
    logic [NUM_DIGITS-1:0][3:0]      nib;
    logic [NUM_DIGITS-1:0][3:0]      nib_adj;
    logic [NUM_DIGITS-1:0][3:0]      digits;
    logic [CNT_W-1:0]                cnt;
    logic                            ovf;
    logic                            overflow_q;
    logic                            accept;
    logic                            last_iter;
    logic [WIDTH-1:0]                load_val;
    logic                            load_ovf;

    // BCD field sits above the binary field; corrections on all digits run in
    // parallel, then the whole register shifts left by one.
    assign nib = sr[WIDTH +: 4*NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_add3 u_add3 (
            .d (nib[g]),
            .q (nib_adj[g])
        );
    end

    // The top bit dropped by the shift is always 0: 9999 fits in four digits.
    assign sr_step = {nib_adj, sr[WIDTH-1:0]} << 1;

    assign accept    = (state == IDLE) && bus.start;
    assign last_iter = (state == CONVERT) && (cnt == CNT_W'(WIDTH - 1));

    // Saturate out-of-range inputs before they ever enter the shift register.
    always_comb begin
        load_val = bus.bin_input;
        load_ovf = 1'b0;
        if (32'(bus.bin_input) > 32'(MAX_VALUE)) begin
            load_val = WIDTH'(MAX_VALUE);
            load_ovf = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: DONE always returns to IDLE, so start there is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = CONVERT;
            CONVERT: if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate while converting, publish on last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            digits     <= '0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            sr  <= {{(4*NUM_DIGITS){1'b0}}, load_val};
            cnt <= '0;
            ovf <= load_ovf;
        end else if (state == CONVERT) begin
            sr  <= sr_step;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                digits     <= sr_step[WIDTH +: 4*NUM_DIGITS];
                overflow_q <= ovf;
            end
        end
    end

    // Status flags decode straight from the registered state so reset clears
    // them immediately.
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.overflow  = overflow_q;
    assign bus.unidades  = digits[0];
    assign bus.decenas   = digits[1];
    assign bus.centenas  = digits[2];
    assign bus.milesimas = digits[3];
endmodule

// File: tb/tb_module_bin_bcd.sv
// Self-checking bench for module_bin_bcd: directed scenarios plus random
// conversions compared against a decimal-arithmetic reference.
module tb_module_bin_bcd;
    localparam int WIDTH = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] exp_dig = '0;
    logic        exp_ovf = 1'b0;
    logic [15:0] dig;

    bcd_if #(.WIDTH(WIDTH)) bus ();

    module_bin_bcd #(.WIDTH(WIDTH), .MAX_VALUE(9999)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign dig = {bus.milesimas, bus.centenas, bus.decenas, bus.unidades};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: saturate, then split into decimal digits.
    function automatic logic [16:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {(v > 9999), 4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // mode 0: plain, 1: re-pulse start mid-conversion, 2: wiggle bin_input.
    // Called at a negedge; start is accepted at the following posedge.
    task automatic do_conv(input int v, input int mode, input string tag);
        logic [16:0] r;
        int cyc;
        r = ref_bcd(v);
        bus.bin_input = WIDTH'(v);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy_acc"}, 32'(bus.busy), 1);
        cyc = 0;
        while (!bus.done && cyc < 40) begin
            chk({tag, "_hold"}, 32'(dig), 32'(exp_dig));
            bus.start = 1'b0;
            if (mode == 1 && cyc == 4) begin
                bus.start = 1'b1;
                bus.bin_input = WIDTH'(5678);
            end
            if (mode == 2) bus.bin_input = WIDTH'($urandom);
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk({tag, "_latency"}, 32'(cyc), WIDTH);
        chk({tag, "_digits"}, 32'(dig), 32'(r[15:0]));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(r[16]));
        chk({tag, "_busy_done"}, 32'(bus.busy), 1);
        exp_dig = r[15:0];
        exp_ovf = r[16];
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(bus.done), 0);
        chk({tag, "_busy_clr"}, 32'(bus.busy), 0);
    endtask

    initial begin
        int cyc;
        int dones;
        int t1;
        int v;
        logic [16:0] r;

        bus.start = 1'b0;
        bus.bin_input = '0;

        // Reset state
        #1;
        chk("rst_digits", 32'(dig), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic conversion and back-to-back
        do_conv(7609, 0, "t1");
        do_conv(3193, 0, "t2a");
        do_conv(94, 0, "t2b");

        // Boundaries
        do_conv(0, 0, "zero");
        do_conv(9999, 0, "max");
        do_conv(10000, 0, "max_p1");
        do_conv(16383, 0, "all_ones");
        do_conv(4095, 0, "mid");

        // Start while busy ignored
        do_conv(1234, 1, "ignore");
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("ignore_extra_done", 32'(dones), 0);

        // Async reset mid-conversion
        bus.bin_input = WIDTH'(7609);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_digits", 32'(dig), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_done", 32'(bus.done), 0);
        chk("arst_ovf", 32'(bus.overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_dig = '0;
        exp_ovf = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("arst_no_done", 32'(dones), 0);
        do_conv(42, 0, "after_rst");

        // Input changes during conversion have no effect
        do_conv(500, 2, "wiggle");

        // start held high: one conversion every WIDTH+2 cycles
        bus.bin_input = WIDTH'(2468);
        bus.start = 1'b1;
        cyc = 0;
        t1 = -1;
        dones = 0;
        while (dones < 2 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                dones++;
                if (dones == 1) t1 = cyc;
            end
        end
        bus.start = 1'b0;
        chk("hold_start_count", 32'(dones), 2);
        chk("hold_start_period", 32'(cyc - t1), WIDTH + 2);
        r = ref_bcd(2468);
        chk("hold_start_digits", 32'(dig), 32'(r[15:0]));
        exp_dig = r[15:0];
        @(negedge clk);
        chk("hold_start_idle", 32'(bus.busy), 0);

        // Random conversions
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0:       v = int'($urandom_range(0, 9999));
                1:       v = int'($urandom_range(10000, 16383));
                default: v = int'($urandom_range(0, 16383));
            endcase
            do_conv(v, 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
